bg_tile_pixel_pipe: RTL and testbench



---
 rtl/bg_tile_pixel_pipe.sv | 135 +++++++++++++
 tb/tb_bg_tile_pixel_pipe.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/bg_tile_pixel_pipe.sv
// Background tile pixel pipeline: scrolled screen coordinate -> tilemap -> 2bpp pattern -> palette color.
// Optional horizontal tile mirroring via map_data[12] when BG_HFLIP_EN is defined.
module bg_tile_pixel_pipe #(
    parameter int MAP_AW = 12,
    parameter int PAT_AW = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_valid,
    input  logic [9:0]        pix_x,
    input  logic [9:0]        pix_y,
    input  logic [6:0]        deltaX,
    input  logic [4:0]        deltaY,
    input  logic [159:0]      bg_pal,
    output logic [MAP_AW-1:0] map_addr,
    input  logic [12:0]       map_data,
    output logic [PAT_AW-1:0] pat_addr,
    input  logic [15:0]       pat_data,
    output logic [4:0]        col_out,
    output logic              col_valid
);

    logic [6:0] sx;
    logic [4:0] sy;
    logic [6:0] eff_sx;
    logic [4:0] eff_sy;
    logic [6:0] tile_col;
    logic [4:0] tile_row;

    logic       v1, v2, v3, v4;
    logic [2:0] fx1, fx2, fx3, fx4;
    logic [2:0] fy1, fy2;
    logic [2:0] pal3, pal4;
    logic [2:0] k;
    logic [1:0] pix_val;
    logic [7:0] pal_base;

    // Vertical wrap comes from the 5-bit tile row, so pix_y[9:8] never matter.
    logic unused_bits;
    assign unused_bits = ^{pix_y[9:8], map_data[12]};

    // A frame_start coinciding with a pixel must apply the new scroll to that pixel.
    always_comb begin
        eff_sx   = frame_start ? deltaX : sx;
        eff_sy   = frame_start ? deltaY : sy;
        tile_col = pix_x[9:3] + eff_sx;
        tile_row = pix_y[7:3] + eff_sy;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx       <= '0;
            sy       <= '0;
            map_addr <= '0;
            v1       <= 1'b0;
            fx1      <= '0;
            fy1      <= '0;
        end else begin
            if (frame_start) begin
                sx <= deltaX;
                sy <= deltaY;
            end
            v1 <= pix_valid;
            if (pix_valid) begin
                map_addr <= MAP_AW'({tile_row, tile_col});
                fx1      <= pix_x[2:0];
                fy1      <= pix_y[2:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2       <= 1'b0;
            fx2      <= '0;
            fy2      <= '0;
            v3       <= 1'b0;
            fx3      <= '0;
            pal3     <= '0;
            pat_addr <= '0;
            v4       <= 1'b0;
            fx4      <= '0;
            pal4     <= '0;
        end else begin
            v2  <= v1;
            fx2 <= fx1;
            fy2 <= fy1;
            v3  <= v2;
            if (v2) begin
                pat_addr <= PAT_AW'({map_data[8:0], fy2});
                pal3     <= map_data[11:9];
                fx3      <= fx2;
            end
            v4   <= v3;
            pal4 <= pal3;
            fx4  <= fx3;
        end
    end

`ifdef BG_HFLIP_EN
    logic flip3, flip4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flip3 <= 1'b0;
            flip4 <= 1'b0;
        end else begin
            if (v2) flip3 <= map_data[12];
            flip4 <= flip3;
        end
    end

    assign k = flip4 ? ~fx4 : fx4;
`else
    assign k = fx4;
`endif

    // Pixel k sits at [15-2k -: 2], i.e. base 2*(7-k) = {~k, 0}.
    always_comb begin
        pix_val  = pat_data[{~k, 1'b0} +: 2];
        pal_base = {5'd0, pal4} * 8'd20 + {6'd0, pix_val} * 8'd5;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_out   <= '0;
            col_valid <= 1'b0;
        end else begin
            col_out   <= v4 ? bg_pal[pal_base +: 5] : 5'd0;
            col_valid <= v4;
        end
    end

endmodule

// File: tb/tb_bg_tile_pixel_pipe.sv
// Self-checking bench for bg_tile_pixel_pipe: scoreboard of expected colors plus directed address checks.
module tb_bg_tile_pixel_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         frame_start = 1'b0;
    logic         pix_valid = 1'b0;
    logic [9:0]   pix_x = '0;
    logic [9:0]   pix_y = '0;
    logic [6:0]   deltaX = '0;
    logic [4:0]   deltaY = '0;
    logic [159:0] bg_pal;
    logic [11:0]  map_addr;
    logic [12:0]  map_data;
    logic [11:0]  pat_addr;
    logic [15:0]  pat_data;
    logic [4:0]   col_out;
    logic         col_valid;

    bg_tile_pixel_pipe #(.MAP_AW(12), .PAT_AW(12)) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid),
        .pix_x(pix_x), .pix_y(pix_y), .deltaX(deltaX), .deltaY(deltaY),
        .bg_pal(bg_pal), .map_addr(map_addr), .map_data(map_data),
        .pat_addr(pat_addr), .pat_data(pat_data), .col_out(col_out), .col_valid(col_valid)
    );

    always #5 clk = ~clk;

    logic [12:0] map_mem [4096];
    logic [15:0] pat_mem [4096];

    always @(posedge clk) begin
        map_data <= map_mem[map_addr];
        pat_data <= pat_mem[pat_addr];
    end

    typedef struct { logic [4:0] col; int due; } exp_t;
    exp_t q[$];

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int n_pulse = 0;
    int p0;
    bit mon_en  = 1'b0;
    logic [6:0] sx_m = '0;
    logic [4:0] sy_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    function automatic logic [11:0] addr_fn(input logic [9:0] x, input logic [9:0] y,
                                            input logic [6:0] sxv, input logic [4:0] syv);
        logic [6:0] c;
        logic [4:0] r;
        c = x[9:3] + sxv;
        r = y[7:3] + syv;
        return {r, c};
    endfunction

    function automatic logic [4:0] color_fn(input logic [9:0] x, input logic [9:0] y,
                                            input logic [6:0] sxv, input logic [4:0] syv);
        logic [12:0] md;
        logic [15:0] pd;
        logic [2:0]  kk;
        logic [1:0]  v;
        int          idx;
        md = map_mem[addr_fn(x, y, sxv, syv)];
        pd = pat_mem[{md[8:0], y[2:0]}];
        kk = x[2:0];
`ifdef BG_HFLIP_EN
        if (md[12]) kk = 3'd7 - kk;
`endif
        idx = 14 - 2 * int'(kk);
        v = pd[idx +: 2];
        return bg_pal[int'(md[11:9]) * 20 + int'(v) * 5 +: 5];
    endfunction

    task automatic drive_pix(input logic [9:0] x, input logic [9:0] y, input logic fs,
                             input logic [6:0] dx, input logic [4:0] dy);
        logic [11:0] ea;
        frame_start = fs;
        deltaX      = dx;
        deltaY      = dy;
        pix_x       = x;
        pix_y       = y;
        pix_valid   = 1'b1;
        if (fs) begin
            sx_m = dx;
            sy_m = dy;
        end
        ea = addr_fn(x, y, sx_m, sy_m);
        q.push_back('{col: color_fn(x, y, sx_m, sy_m), due: cyc + 5});
        @(negedge clk);
        check("map_addr", map_addr, ea);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            frame_start = 1'b0;
            pix_valid   = 1'b0;
            @(negedge clk);
        end
    endtask

    // Output monitor: every resolved pixel must land exactly on its due cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (rst) begin
                check("rst_col_valid", col_valid, 0);
                check("rst_col_out", col_out, 0);
            end else if (q.size() > 0 && q[0].due == cyc) begin
                exp_t e;
                e = q.pop_front();
                check("col_valid", col_valid, 1);
                if (col_valid) begin
                    n_pulse++;
                    check("col_out", col_out, e.col);
                end
            end else begin
                check("idle_col_valid", col_valid, 0);
                check("idle_col_out", col_out, 0);
            end
        end
    end

    initial begin
        for (int a = 0; a < 4096; a++) begin
            map_mem[a] = 13'((a * 37) ^ (a >> 3));
            pat_mem[a] = 16'((a * 40503) ^ 23130);
        end
        for (int p = 0; p < 8; p++)
            for (int v = 0; v < 4; v++)
                bg_pal[p * 20 + v * 5 +: 5] = 5'((p * 4 + v + 3) % 32);
        bg_pal[40 +: 5] = 5'd7;
        bg_pal[45 +: 5] = 5'd9;
        map_mem[12'h081] = {1'b0, 3'd2, 9'd5};
        pat_mem[12'h02A] = 16'h4000;
        map_mem[12'h0FF] = {1'b1, 3'd5, 9'd300};
        pat_mem[{9'd300, 3'd0}] = 16'h0003;
        mon_en = 1'b1;

        repeat (3) begin
            @(negedge clk);
            check("rst_map_addr", map_addr, 0);
            check("rst_pat_addr", pat_addr, 0);
        end
        rst = 1'b0;
        idle(2);

        // Basic pixel (13,10), no scroll: tile 5, palette 2, fine_y 2, k=5 -> v=0.
        drive_pix(10'd13, 10'd10, 1'b0, 7'd0, 5'd0);
        check("basic_map_addr", map_addr, 12'h081);
        idle(1);
        idle(1);
        check("basic_pat_addr", pat_addr, 12'h02A);
        idle(2);
        check("basic_col_valid", col_valid, 1);
        check("basic_col_out", col_out, 7);

        // Scroll bypass on frame_start plus wrap in both axes.
        drive_pix(10'd8, 10'd0, 1'b1, 7'd127, 5'd31);
        check("bypass_map_addr", map_addr, 12'hF80);
        drive_pix(10'd8, 10'd8, 1'b0, 7'd127, 5'd31);
        check("wrap_map_addr", map_addr, 12'h000);
        idle(5);

        // 16-slot burst with a bubble in slot 8.
        p0 = n_pulse;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) idle(1);
            else drive_pix(10'(16 * i + 3), 10'(40 + i), 1'b0, 7'd127, 5'd31);
        end
        idle(6);
        check("burst_pulses", n_pulse - p0, 15);

        // Flip-flagged tile at x=0 with only pixel 7 non-zero.
        drive_pix(10'd0, 10'd16, 1'b0, 7'd127, 5'd31);
        idle(4);
`ifdef BG_HFLIP_EN
        check("hflip_col_out", col_out, 26);
`else
        check("hflip_col_out", col_out, 23);
`endif

        // Reset with pixels in flight: they must never emerge.
        drive_pix(10'd24, 10'd32, 1'b0, 7'd127, 5'd31);
        drive_pix(10'd32, 10'd32, 1'b0, 7'd127, 5'd31);
        drive_pix(10'd40, 10'd32, 1'b0, 7'd127, 5'd31);
        pix_valid   = 1'b0;
        frame_start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        q.delete();
        sx_m = '0;
        sy_m = '0;
        @(negedge clk);
        check("midrst_map_addr", map_addr, 0);
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        p0 = n_pulse;
        idle(6);
        check("flushed_pulses", n_pulse - p0, 0);
        drive_pix(10'd13, 10'd10, 1'b0, 7'd0, 5'd0);
        idle(6);
        check("post_reset_pulses", n_pulse - p0, 1);

        check("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
